traffic_accumulator_stream: RTL
===============================

TRAFFIC_ACCUMULATOR_STREAM -- requirements
Module: traffic_accumulator_stream

Interface
REQ-001 Parameter NOC_DW, default 32, meaning the width of stream data words.
REQ-002 Parameter ACC_DW, default 64, meaning the accumulator width; it SHALL be at least NOC_DW.
REQ-003 Parameter FIFO_DEPTH, default 4, meaning input FIFO entries; it SHALL be a power of 2 and at least 2.
REQ-004 Parameter WINDOW, default 4, meaning words per emitted sum in WINDOW mode; it SHALL be at least 1.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port reset, input, 1 bit: reset, synchronous and active-low; reset==0 SHALL reset the block at the next rising edge of clk.
REQ-007 Port mode, input, 2 bits: 00 PASS, 01 ACCUM, 10 WINDOW, 11 reserved (behaves as PASS).
REQ-008 Port s_tdata, input, NOC_DW bits: input word.
REQ-009 Port s_tvalid, input, 1 bit: input word valid.
REQ-010 Port s_tready, output, 1 bit: the block can accept an input word.
REQ-011 Port m_tdata, output, NOC_DW bits: output word.
REQ-012 Port m_tvalid, output, 1 bit: output word valid.
REQ-013 Port m_tready, input, 1 bit: downstream accepts the output word.
REQ-014 Port acc_out, output, ACC_DW bits: the current accumulator register.
REQ-015 Port overflow, output, 1 bit: sticky flag for accumulator carry-out.
REQ-016 Port fifo_count, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-017 An input transfer SHALL occur on an edge where s_tvalid=1 and s_tready=1; the word SHALL be written to the FIFO tail.
REQ-018 s_tready SHALL be registered-state-only: 1 iff fifo_count<FIFO_DEPTH and reset=1. When full, s_tready SHALL be 0 even if a pop occurs in the same cycle.
REQ-019 out_free SHALL be defined as (m_tvalid=0 or m_tready=1). A pop SHALL occur when the FIFO is non-empty, out_free=1 and mode equals mode_q (REQ-025).
REQ-020 A simultaneous push and pop SHALL leave fifo_count unchanged. FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 PASS mode: each pop SHALL load m_tdata with the popped word and set m_tvalid=1.
REQ-022 ACCUM mode: each pop SHALL compute sum_next = acc + zero-extended word, wrapping modulo 2^ACC_DW. acc SHALL take sum_next, m_tdata SHALL take sum_next[NOC_DW-1:0], and m_tvalid SHALL be set to 1.
REQ-023 WINDOW mode: each pop SHALL add the word as in REQ-022 and increment the window counter wcnt.
  - On the pop that makes wcnt reach WINDOW, m_tdata SHALL take sum_next[NOC_DW-1:0], m_tvalid SHALL be set to 1, acc SHALL clear to 0 and wcnt SHALL clear to 0.
  - Other pops SHALL update acc only and SHALL NOT change m_tvalid or m_tdata.
REQ-024 overflow SHALL be set to 1 on any addition with carry out of bit ACC_DW-1, and SHALL be cleared only by reset.
REQ-025 mode_q SHALL register mode every cycle. In a cycle where mode differs from mode_q, acc and wcnt SHALL clear to 0 and no pop SHALL occur.
REQ-026 An output transfer SHALL occur when m_tvalid=1 and m_tready=1; m_tvalid SHALL fall to 0 unless a new pop loads the output in the same cycle.
REQ-027 While m_tvalid=1 and m_tready=0, m_tdata and m_tvalid SHALL hold stable.
REQ-028 Latency: a word accepted at edge N into an empty FIFO, with out_free=1, SHALL produce m_tvalid=1 after edge N+1.
REQ-029 Throughput SHALL be one word per cycle when m_tready is held at 1.

Reset
REQ-030 At an edge with reset=0, the block SHALL set: FIFO empty, fifo_count=0, m_tvalid=0, m_tdata=0, acc_out=0, overflow=0, wcnt=0, mode_q=mode.
REQ-031 While reset=0, s_tready SHALL be 0.
REQ-032 Reset asserted mid-stream SHALL discard all FIFO contents and any pending output word.

Verification
REQ-033 PASS, m_tready=1: inputs 5,6,7 -> outputs 5,6,7; each output one edge after its pop; 2-cycle latency.
REQ-034 ACCUM: inputs 1,2,3,4 -> m_tdata 1,3,6,10; acc_out=10.
REQ-035 WINDOW with WINDOW=4: inputs 1 through 8 -> exactly two outputs, 10 and 26; acc_out=0 after the 8th pop.
REQ-036 Backpressure: m_tready=0, 6 words offered with FIFO_DEPTH=4 -> first word held on m_tdata, one word popped, 4 words in FIFO, s_tready=0. Releasing m_tready -> all accepted words emerge in order, with none lost or duplicated.
REQ-037 ACC_DW=NOC_DW=32, ACCUM mode: inputs 0xFFFFFFFF then 2 -> m_tdata 0xFFFFFFFF then 1; overflow=1 and stays 1 until reset.
REQ-038 Reset mid-operation: FIFO holds 3 words and m_tvalid=1, reset=0 for one edge -> fifo_count=0, m_tvalid=0, acc_out=0, no stale words emerge; mode switch 01->10 clears acc_out.

Source files
------------

// File: rtl/traffic_accumulator_stream.sv
// traffic_accumulator_stream: FIFO-buffered stream with pass, running-sum and windowed-sum output modes
module traffic_accumulator_stream #(
  parameter int NOC_DW     = 32,
  parameter int ACC_DW     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int WINDOW     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    mode,
  input  logic [NOC_DW-1:0]             s_tdata,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  output logic [NOC_DW-1:0]             m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [ACC_DW-1:0]             acc_out,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(WINDOW + 1);
  logic [NOC_DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [NOC_DW-1:0] tdata_q, tdata_d, head;
  logic              tvalid_q, tvalid_d, ovf_q, ovf_d;
  logic [ACC_DW-1:0] acc_q, acc_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic [1:0]        mode_q;
  logic              push, pop, mode_chg, is_acc, is_win, win_done, load;
  logic [ACC_DW:0]   sum;
  assign s_tready   = reset && (cnt_q < (AW+1)'(FIFO_DEPTH));
  assign m_tdata    = tdata_q;
  assign m_tvalid   = tvalid_q;
  assign acc_out    = acc_q;
  assign overflow   = ovf_q;
  assign fifo_count = cnt_q;
  // handshakes, FIFO pointers and the per-mode datapath; a mode change stalls popping for one cycle
  always_comb begin
    head     = mem_q[rd_q];
    mode_chg = mode != mode_q;
    push     = s_tvalid && s_tready;
    pop      = (cnt_q != '0) && (!tvalid_q || m_tready) && !mode_chg;
    is_acc   = mode_q == 2'b01;
    is_win   = mode_q == 2'b10;
    sum      = {1'b0, acc_q} + {{(ACC_DW-NOC_DW+1){1'b0}}, head};
    win_done = is_win && (wcnt_q == WW'(WINDOW - 1));
    load     = pop && (!is_win || win_done);
    wr_d     = push ? wr_q + 1'b1 : wr_q;
    rd_d     = pop ? rd_q + 1'b1 : rd_q;
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    tvalid_d = load || (tvalid_q && !m_tready);
    tdata_d  = load ? ((is_acc || is_win) ? sum[NOC_DW-1:0] : head) : tdata_q;
    acc_d    = (mode_chg || (pop && win_done)) ? '0 : (pop && (is_acc || is_win)) ? sum[ACC_DW-1:0] : acc_q;
    wcnt_d   = (mode_chg || (pop && win_done)) ? '0 : (pop && is_win) ? wcnt_q + 1'b1 : wcnt_q;
    ovf_d    = ovf_q || (pop && (is_acc || is_win) && sum[ACC_DW]);
  end
  // control and accumulator state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      acc_q    <= '0;
      wcnt_q   <= '0;
      ovf_q    <= 1'b0;
      mode_q   <= mode;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      acc_q    <= acc_d;
      wcnt_q   <= wcnt_d;
      ovf_q    <= ovf_d;
      mode_q   <= mode;
    end
  end
  // FIFO storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= s_tdata;
  end
endmodule
